// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 keypad encoder.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  // Layout: row0 = 1 2 3 +, row1 = 4 5 6 -, row2 = 7 8 9 *, row3 = C 0 = /
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = KEY_ADD;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = KEY_SUB;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = KEY_MUL;
      4'hC: code = KEY_CLR;
      4'hD: code = 4'd0;
      4'hE: code = KEY_EQ;
      default: code = KEY_DIV;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_stable_cnt.sv
// Counts consecutive cycles a level stays high; done on the cycle the count hits target.
module keypad_stable_cnt #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         level,
  input  logic         restart,
  input  logic [W-1:0] target,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || restart || !level) cnt <= '0;
    else                            cnt <= cnt + 1'b1;
  end

  assign done = level && !restart && (cnt == target);

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner, debouncer and encoder.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of held keys.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  state_t        state;
  logic [1:0]    row, lcol;
  logic [SW-1:0] scan_cnt;
  logic [3:0]    col_m, col_s;
  logic          lvl, restart, stable_done, rpt_fire;

  function automatic logic [1:0] low_col(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!c[i]) idx = 2'(i);
    return idx;
  endfunction

  // Synchronizer idles high (released) so reset never fakes a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= col_n;
      col_s <= col_m;
    end
  end

  // One counter serves both press (column low) and release (column high) debounce.
  assign lvl     = (state == RELEASE) ? col_s[lcol] : ~col_s[lcol];
  assign restart = (state == SCAN) || (state == HELD);

  keypad_stable_cnt #(.W(DW)) u_stable (
    .clk     (clk),
    .reset   (reset),
    .level   (lvl),
    .restart (restart),
    .target  (DW'(DEBOUNCE_CYCLES - 1)),
    .done    (stable_done)
  );

`ifdef KEYPAD_REPEAT_EN
  logic [31:0] hcnt;
  logic        rpt_first;

  assign rpt_fire = (state == HELD) && (key_code < KEY_EQ) &&
                    (hcnt == (rpt_first ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_PERIOD - 1)));

  // Frozen in RELEASE so a release glitch does not shift the repeat cadence.
  always_ff @(posedge clk) begin
    if (reset || state == DEBOUNCE) begin
      hcnt      <= '0;
      rpt_first <= 1'b1;
    end else if (state == HELD) begin
      if (rpt_fire) begin
        hcnt      <= '0;
        rpt_first <= 1'b0;
      end else begin
        hcnt <= hcnt + 32'd1;
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      row       <= 2'd0;
      lcol      <= 2'd0;
      scan_cnt  <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
            scan_cnt <= '0;
            if (col_s != 4'hF) begin
              lcol  <= low_col(col_s);
              state <= DEBOUNCE;
            end else begin
              row <= row + 2'd1;
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (col_s[lcol]) begin
            row   <= row + 2'd1;
            state <= SCAN;
          end else if (stable_done) begin
            key_code  <= key_map(row, lcol);
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
          end
        end
        HELD: begin
          if (rpt_fire)    key_valid <= 1'b1;
          if (col_s[lcol]) state     <= RELEASE;
        end
        default: begin
          if (!col_s[lcol]) begin
            state <= HELD;
          end else if (stable_done) begin
            key_held <= 1'b0;
            row      <= row + 2'd1;
            state    <= SCAN;
          end
        end
      endcase
    end
  end

  assign row_n = ~(4'b0001 << row);

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboarded bench for keypad_encoder with a behavioural 4x4 key matrix.
module tb_keypad_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_n, row_n, key_code;
  logic       key_valid, key_held;
  logic [3:0][3:0] pressed;

  int         vecs = 0;
  int         errs = 0;
  int         cyc  = 0;
  logic [3:0] exp_q[$];
  logic       prev_v = 1'b0;

  keypad_encoder #(
    .SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(40), .REPEAT_PERIOD(10)
  ) dut (
    .clk(clk), .reset(reset), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A pressed key pulls its column low only while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe consumes one expected code.
  always @(negedge clk) begin
    if (key_valid) begin
      check("strobe_not_back_to_back", {31'd0, prev_v}, 32'd0);
      if (exp_q.size() == 0) check("unexpected_strobe", {28'd0, key_code}, 32'hFFFF_FFFF);
      else                   check("key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
    end
    prev_v = key_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_row(input logic [3:0] r);
    int n = 0;
    while (row_n !== r && n < 40) begin @(negedge clk); n++; end
    if (row_n !== r) check("row_timeout", {28'd0, row_n}, {28'd0, r});
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (key_valid !== 1'b1 && n < 120) begin @(negedge clk); n++; end
    if (key_valid !== 1'b1) check(nm, {31'd0, key_valid}, 32'd1);
  endtask

  task automatic wait_released(input string nm);
    int n = 0;
    while (key_held !== 1'b0 && n < 60) begin @(negedge clk); n++; end
    check(nm, {31'd0, key_held}, 32'd0);
  endtask

  task automatic press(input int r, input int c);
    wait_row(4'b1110);
    pressed[r][c] = 1'b1;
  endtask

  initial begin
    int t0;
    pressed = '0;
    reset   = 1'b1;
    tick(3);
    reset = 1'b0;
    check("reset_row_n", {28'd0, row_n}, 32'hE);
    check("reset_key_code", {28'd0, key_code}, 32'd0);
    check("reset_key_valid", {31'd0, key_valid}, 32'd0);
    check("reset_key_held", {31'd0, key_held}, 32'd0);

    // 1: idle scan, four cycles per row
    for (int i = 0; i < 20; i++) begin
      check("idle_scan_row_n", {28'd0, row_n}, {28'd0, ~(4'b0001 << ((i / 4) % 4))});
      tick(1);
    end

    // 2: '6' with exact accept latency and release timing
    exp_q.push_back(4'd6);
    press(1, 2);
    wait_row(4'b1101);
    t0 = cyc;
    wait_valid("six_strobe");
    check("six_latency", 32'(cyc - t0), 32'd12);
    check("six_held", {31'd0, key_held}, 32'd1);
    tick(40);
    check("six_still_held", {31'd0, key_held}, 32'd1);
    pressed[1][2] = 1'b0;
    tick(10);
    check("six_held_during_release", {31'd0, key_held}, 32'd1);
    tick(1);
    check("six_released", {31'd0, key_held}, 32'd0);
    check("six_code_kept", {28'd0, key_code}, 32'd6);

    // 3: 'C' with 3-cycle bounce before settling
    exp_q.push_back(4'd15);
    wait_row(4'b0111);
    pressed[3][0] = 1'b1;
    tick(4);
    repeat (3) begin
      pressed[3][0] = 1'b0; tick(3);
      pressed[3][0] = 1'b1; tick(3);
    end
    wait_valid("clr_strobe");
    tick(10);
    pressed[3][0] = 1'b0;
    wait_released("clr_released");
    check("clr_code", {28'd0, key_code}, 32'd15);

    // 4: '5' held, '9' added, '5' released -> '9' accepted afterwards
    exp_q.push_back(4'd5);
    press(1, 1);
    wait_valid("five_strobe");
    exp_q.push_back(4'd9);
    pressed[2][2] = 1'b1;
    tick(10);
    check("five_code_while_nine_down", {28'd0, key_code}, 32'd5);
    pressed[1][1] = 1'b0;
    wait_released("five_released");
    wait_valid("nine_strobe");
    pressed[2][2] = 1'b0;
    wait_released("nine_released");

    // 5: reset while '+' is held
    exp_q.push_back(4'd10);
    press(0, 3);
    wait_valid("plus_strobe");
    tick(3);
    reset = 1'b1;
    tick(1);
    check("midpress_reset_row_n", {28'd0, row_n}, 32'hE);
    check("midpress_reset_held", {31'd0, key_held}, 32'd0);
    check("midpress_reset_code", {28'd0, key_code}, 32'd0);
    reset = 1'b0;
    exp_q.push_back(4'd10);
    wait_valid("plus_restrobe");
    pressed[0][3] = 1'b0;
    wait_released("plus_released");

    // 6: long hold of '7' and '='
`ifdef KEYPAD_REPEAT_EN
    repeat (6) exp_q.push_back(4'd7);
`else
    exp_q.push_back(4'd7);
`endif
    press(2, 0);
    wait_valid("seven_strobe");
    tick(82);
    pressed[2][0] = 1'b0;
    wait_released("seven_released");
    exp_q.push_back(4'd14);
    press(3, 2);
    wait_valid("eq_strobe");
    tick(82);
    pressed[3][2] = 1'b0;
    wait_released("eq_released");

    tick(20);
    check("expected_strobes_all_seen", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
